firebird7_in_gate1_data_mux_ctrl: RTL and testbench
===================================================

// Module: firebird7_in_gate1_data_mux_ctrl
// PURPOSE
//  - IJTAG-side controller for a W-bit functional/IJTAG data mux. Its TDR (shift/capture/update) holds the override data and a select request.
//  - Before driving ijtag_select it runs a safe hand-over with the functional logic: hold request, idle acknowledge, settle, then override.
//  - Sits between the SIB-gated IJTAG network and the data mux select/data inputs, inside gate1.
// PARAMETERS
//  - W            3   data width of the controlled mux
//  - SETTLE_CYC   2   cycles between idle acknowledge and select assert, and between select release and hold drop; legal range >=1
//  - TIMEOUT_CYC  8   max cycles waiting in HOLD for func_idle; legal range >=1
// PORTS
//  - ijtag_tck           in   1   clock, the only clock
//  - ijtag_reset         in   1   reset, synchronous, active-high
//  - ijtag_sel           in   1   TDR selected by the network
//  - ijtag_ce            in   1   capture enable
//  - ijtag_se            in   1   shift enable
//  - ijtag_ue            in   1   update enable
//  - ijtag_si            in   1   scan in
//  - ijtag_so            out  1   scan out, equal to sr[0]
//  - functional_data_in  in   W   functional value, captured for observe
//  - func_idle           in   1   functional side has quiesced (level)
//  - func_hold_req       out  1   request for the functional side to quiesce
//  - ijtag_select        out  1   mux select, 1 = IJTAG data drives the mux
//  - ijtag_data_out      out  W   override data to the mux ijtag_data_in
// BEHAVIOUR
//  - TDR shift reg sr[W+1:0]: [W+1]=req/timeout, [W]=active, [W-1:0]=data. Scan order is ijtag_si -> sr[W+1] -> sr[0] -> ijtag_so.
//  - All TDR actions are qualified by ijtag_sel. ce has priority over se.
//    - Capture: sr <= {timeout_flag, state==ACTIVE, functional_data_in}.
//    - Shift: sr <= {ijtag_si, sr[W+1:1]}.
//    - Update (ue, independent of ce/se): data_reg <= sr[W-1:0]; req <= sr[W+1]; timeout_flag <= 0. sr[W] is ignored on update.
//  - ijtag_data_out = data_reg, registered. A data update while ACTIVE takes effect on the next edge.
//  - FSM states: IDLE, HOLD, SETTLE, ACTIVE, RELEASE. One counter cnt, width $clog2(max(SETTLE_CYC,TIMEOUT_CYC)+1).
//  - IDLE: outputs 0. req=1 -> HOLD with cnt=0. func_hold_req is 1 on the cycle after the update edge.
//  - HOLD: func_hold_req=1.
//    - req=0 -> IDLE (abort, select never asserted).
//    - func_idle=1 -> SETTLE with cnt=0.
//    - cnt==TIMEOUT_CYC-1 with func_idle=0 -> timeout_flag<=1, go IDLE.
//    - func_idle and timeout in the same cycle: func_idle wins.
//  - SETTLE: func_hold_req=1. req=0 -> IDLE. cnt==SETTLE_CYC-1 -> ACTIVE.
//  - ACTIVE: func_hold_req=1, ijtag_select=1. req=0 -> RELEASE with cnt=0. func_idle is no longer monitored.
//  - RELEASE: ijtag_select=0, func_hold_req=1. cnt==SETTLE_CYC-1 -> IDLE, hold drops.
//    - req=1 during RELEASE is remembered and acted on from IDLE on the next cycle.
//  - ijtag_select and func_hold_req are registered, decoded from the next state. ijtag_select never toggles with func_hold_req=0.
//  - Reset (any state): sr, data_reg, req, timeout_flag = 0; state IDLE; all outputs 0 on the next edge.
//    - Mid-ACTIVE reset drops select and hold in the same cycle, by design.
// CONFIGURATION
//  - FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN defined:
//    - HOLD timeout and timeout_flag are implemented as above.
//  - Macro undefined:
//    - HOLD waits indefinitely for func_idle or req=0; the timeout exit and its cnt compare are removed.
//    - timeout_flag is tied 0 and captures 0.
// STRUCTURE
//  - Package firebird7_in_gate1_data_mux_ctrl_pkg holds:
//    - state enum;
//    - localparam bit indices REQ_BIT, ACT_BIT, relative to W;
//    - cnt-width function.
//  - Sub-module firebird7_in_gate1_data_mux_ctrl_tdr holds sr, data_reg and req, with the shift/capture/update rules above.
//  - The top holds the FSM, cnt and timeout_flag.
// TESTING (W=3, SETTLE_CYC=2, TIMEOUT_CYC=8, macro defined unless noted)
//  - Reset: assert ijtag_reset for 1 cycle mid-ACTIVE -> next edge select=0, hold=0, data_out=0; capture reads 0.
//  - Hand-over:
//    - Shift/update {req=1, data=3'b101}; func_idle rises 3 cycles after hold.
//    - Expect hold 1 cycle after update, select exactly 2 cycles after the func_idle sample, data_out=101.
//    - Capture reads active=1.
//  - Release: update req=0 while ACTIVE -> select=0 next edge, hold=0 two cycles later, state IDLE.
//  - Timeout:
//    - Keep func_idle=0 -> after 8 HOLD cycles hold=0 and select never asserts; capture reads sr[4]=1.
//    - The next update clears it to 0.
//    - With the macro undefined, hold stays 1 for 50 cycles.
//  - Abort: req=0 during SETTLE -> IDLE, select never asserts, hold drops next edge.
//  - TDR: ce and se both high -> capture wins. ijtag_sel=0 -> ce/se/ue ignored.
//    - Capture with functional_data_in=3'b110 -> sr[2:0]=110 shifted out LSB first on ijtag_so.

Source files
------------

// File: rtl/firebird7_in_gate1_data_mux_ctrl_pkg.sv
// Shared state encoding, TDR bit offsets and counter sizing for the gate1 data mux controller.
package firebird7_in_gate1_data_mux_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HOLD    = 3'd1;
  localparam state_t ST_SETTLE  = 3'd2;
  localparam state_t ST_ACTIVE  = 3'd3;
  localparam state_t ST_RELEASE = 3'd4;

  // TDR control bits sit above the W data bits: sr[W+REQ_BIT], sr[W+ACT_BIT]
  localparam int REQ_BIT = 1;
  localparam int ACT_BIT = 0;

  function automatic int cnt_width(input int settle_cyc, input int timeout_cyc);
    int max_cyc;
    max_cyc = (settle_cyc > timeout_cyc) ? settle_cyc : timeout_cyc;
    return $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_data_mux_ctrl_tdr.sv
// IJTAG TDR for the data mux controller: shift/capture/update of override data and select request.
module firebird7_in_gate1_data_mux_ctrl_tdr
  import firebird7_in_gate1_data_mux_ctrl_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         ijtag_tck,
  input  logic         ijtag_reset,
  input  logic         ijtag_sel,
  input  logic         ijtag_ce,
  input  logic         ijtag_se,
  input  logic         ijtag_ue,
  input  logic         ijtag_si,
  input  logic         timeout_flag,
  input  logic         active,
  input  logic [W-1:0] functional_data_in,
  input  logic         req_clr,
  output logic         ijtag_so,
  output logic         req,
  output logic [W-1:0] data_reg,
  output logic         upd
);

  logic [W+1:0] sr;
  logic [W+1:0] cap_word;

  always_comb begin
    cap_word                = '0;
    cap_word[W-1:0]         = functional_data_in;
    cap_word[W + ACT_BIT]   = active;
    cap_word[W + REQ_BIT]   = timeout_flag;
  end

  assign upd      = ijtag_sel & ijtag_ue;
  assign ijtag_so = sr[0];

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sr       <= '0;
      data_reg <= '0;
      req      <= 1'b0;
    end else begin
      if (ijtag_sel && ijtag_ce)
        sr <= cap_word;
      else if (ijtag_sel && ijtag_se)
        sr <= {ijtag_si, sr[W+1:1]};
      // a timed-out request is dropped so IDLE does not immediately retry
      if (upd) begin
        data_reg <= sr[W-1:0];
        req      <= sr[W + REQ_BIT];
      end else if (req_clr) begin
        req <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/firebird7_in_gate1_data_mux_ctrl.sv
// IJTAG-side controller for the gate1 functional/IJTAG data mux with a safe hand-over sequence.
// Optional HOLD timeout enabled by defining FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN.
//   state   | meaning
//   IDLE    | functional logic owns the mux, no hold
//   HOLD    | hold requested, waiting for func_idle
//   SETTLE  | functional side idle, settling before select
//   ACTIVE  | IJTAG data drives the mux
//   RELEASE | select dropped, settling before hold drops
module firebird7_in_gate1_data_mux_ctrl
  import firebird7_in_gate1_data_mux_ctrl_pkg::*;
#(
  parameter int W           = 3,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic         ijtag_tck,
  input  logic         ijtag_reset,
  input  logic         ijtag_sel,
  input  logic         ijtag_ce,
  input  logic         ijtag_se,
  input  logic         ijtag_ue,
  input  logic         ijtag_si,
  output logic         ijtag_so,
  input  logic [W-1:0] functional_data_in,
  input  logic         func_idle,
  output logic         func_hold_req,
  output logic         ijtag_select,
  output logic [W-1:0] ijtag_data_out
);

  localparam int CW = cnt_width(SETTLE_CYC, TIMEOUT_CYC);
  localparam logic [CW-1:0] SETTLE_LD  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYC - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          timeout_flag;
  logic          to_set;
  logic          req;
  logic          upd;

  firebird7_in_gate1_data_mux_ctrl_tdr #(.W(W)) u_tdr (
    .ijtag_tck          (ijtag_tck),
    .ijtag_reset        (ijtag_reset),
    .ijtag_sel          (ijtag_sel),
    .ijtag_ce           (ijtag_ce),
    .ijtag_se           (ijtag_se),
    .ijtag_ue           (ijtag_ue),
    .ijtag_si           (ijtag_si),
    .timeout_flag       (timeout_flag),
    .active             (state == ST_ACTIVE),
    .functional_data_in (functional_data_in),
    .req_clr            (to_set),
    .ijtag_so           (ijtag_so),
    .req                (req),
    .data_reg           (ijtag_data_out),
    .upd                (upd)
  );

  // cnt is a down-counter loaded on state entry; terminal count is zero
  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - CW'(1) : cnt;
    to_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_n = ST_HOLD;
          cnt_n   = TIMEOUT_LD;
        end
      end
      ST_HOLD: begin
        if (!req) begin
          state_n = ST_IDLE;
        end else if (func_idle) begin
          state_n = ST_SETTLE;
          cnt_n   = SETTLE_LD;
        end
`ifdef FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
        else if (cnt == '0) begin
          state_n = ST_IDLE;
          to_set  = 1'b1;
        end
`endif
      end
      ST_SETTLE: begin
        if (!req)
          state_n = ST_IDLE;
        else if (cnt == '0)
          state_n = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!req) begin
          state_n = ST_RELEASE;
          cnt_n   = SETTLE_LD;
        end
      end
      ST_RELEASE: begin
        if (cnt == '0)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // without the timeout build to_set is constant 0, so timeout_flag stays 0
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      timeout_flag  <= 1'b0;
      func_hold_req <= 1'b0;
      ijtag_select  <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      func_hold_req <= (state_n != ST_IDLE);
      ijtag_select  <= (state_n == ST_ACTIVE);
      if (to_set)
        timeout_flag <= 1'b1;
      else if (upd)
        timeout_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_firebird7_in_gate1_data_mux_ctrl.sv
// Directed bench for firebird7_in_gate1_data_mux_ctrl (W=3, SETTLE_CYC=2, TIMEOUT_CYC=8).
// Timeout expectations follow FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN when defined.
module tb_firebird7_in_gate1_data_mux_ctrl;

  localparam int W = 3;

  logic         ijtag_tck = 1'b0;
  logic         ijtag_reset;
  logic         ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic         ijtag_so;
  logic [W-1:0] functional_data_in;
  logic         func_idle;
  logic         func_hold_req;
  logic         ijtag_select;
  logic [W-1:0] ijtag_data_out;

  int checks = 0;
  int errors = 0;
  logic [4:0] v;
  logic       sel_seen;
  logic       ok;

  firebird7_in_gate1_data_mux_ctrl #(.W(W), .SETTLE_CYC(2), .TIMEOUT_CYC(8)) dut (
    .ijtag_tck          (ijtag_tck),
    .ijtag_reset        (ijtag_reset),
    .ijtag_sel          (ijtag_sel),
    .ijtag_ce           (ijtag_ce),
    .ijtag_se           (ijtag_se),
    .ijtag_ue           (ijtag_ue),
    .ijtag_si           (ijtag_si),
    .ijtag_so           (ijtag_so),
    .functional_data_in (functional_data_in),
    .func_idle          (func_idle),
    .func_hold_req      (func_hold_req),
    .ijtag_select       (ijtag_select),
    .ijtag_data_out     (ijtag_data_out)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  task automatic tick();
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic shift_word(input logic [4:0] w);
    ijtag_sel = 1'b1;
    ijtag_se  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ijtag_si = w[i];
      tick();
    end
    ijtag_se = 1'b0;
    ijtag_si = 1'b0;
  endtask

  task automatic pulse_update();
    ijtag_sel = 1'b1;
    ijtag_ue  = 1'b1;
    tick();
    ijtag_ue  = 1'b0;
  endtask

  task automatic capture_read(input logic with_se, output logic [4:0] w);
    ijtag_sel = 1'b1;
    ijtag_ce  = 1'b1;
    ijtag_se  = with_se;
    tick();
    ijtag_ce  = 1'b0;
    ijtag_se  = 1'b1;
    ijtag_si  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w[i] = ijtag_so;
      tick();
    end
    ijtag_se = 1'b0;
  endtask

  initial begin
    ijtag_reset = 1'b1;
    ijtag_sel = 1'b0; ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
    functional_data_in = 3'b000;
    func_idle = 1'b0;
    tick();
    tick();
    ijtag_reset = 1'b0;
    chk("rst_select", 8'(ijtag_select), 8'h0);
    chk("rst_hold", 8'(func_hold_req), 8'h0);
    chk("rst_data", 8'(ijtag_data_out), 8'h0);
    chk("rst_so", 8'(ijtag_so), 8'h0);

    // capture beats shift when ce and se are both high
    functional_data_in = 3'b110;
    capture_read(1'b1, v);
    chk("cap_ce_wins", 8'(v), 8'h06);

    // deselected TDR ignores ce/se/ue
    shift_word(5'b00101);
    chk("shift_so", 8'(ijtag_so), 8'h1);
    ijtag_sel = 1'b0; ijtag_ce = 1'b1; ijtag_ue = 1'b1;
    tick();
    ijtag_ce = 1'b0; ijtag_ue = 1'b0;
    chk("nosel_ce", 8'(ijtag_so), 8'h1);
    chk("nosel_ue", 8'(ijtag_data_out), 8'h0);
    ijtag_se = 1'b1;
    tick();
    ijtag_se = 1'b0;
    chk("nosel_se", 8'(ijtag_so), 8'h1);

    // hand-over
    shift_word(5'b10101);
    pulse_update();
    tick();
    chk("ho_hold", 8'(func_hold_req), 8'h1);
    chk("ho_sel0", 8'(ijtag_select), 8'h0);
    chk("ho_data", 8'(ijtag_data_out), 8'h5);
    tick(); tick(); tick();
    chk("ho_wait_sel", 8'(ijtag_select), 8'h0);
    func_idle = 1'b1;
    tick();
    chk("ho_settle0", 8'(ijtag_select), 8'h0);
    tick();
    chk("ho_settle1", 8'(ijtag_select), 8'h0);
    tick();
    chk("ho_active_sel", 8'(ijtag_select), 8'h1);
    chk("ho_active_hold", 8'(func_hold_req), 8'h1);
    func_idle = 1'b0;
    capture_read(1'b0, v);
    chk("ho_cap_active", 8'(v), 8'h0E);
    chk("ho_idle_ignored", 8'(ijtag_select), 8'h1);

    shift_word(5'b10011);
    pulse_update();
    chk("act_data_upd", 8'(ijtag_data_out), 8'h3);
    chk("act_data_sel", 8'(ijtag_select), 8'h1);

    // release
    shift_word(5'b00011);
    pulse_update();
    chk("rel_sel_still", 8'(ijtag_select), 8'h1);
    tick();
    chk("rel_sel0", 8'(ijtag_select), 8'h0);
    chk("rel_hold1", 8'(func_hold_req), 8'h1);
    tick();
    chk("rel_hold1b", 8'(func_hold_req), 8'h1);
    tick();
    chk("rel_hold0", 8'(func_hold_req), 8'h0);
    capture_read(1'b0, v);
    chk("rel_cap_idle", 8'(v), 8'h06);

    // timeout in HOLD
    shift_word(5'b10000);
    pulse_update();
    tick();
    chk("to_hold1", 8'(func_hold_req), 8'h1);
`ifdef FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
    sel_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      sel_seen = sel_seen | ijtag_select;
    end
    chk("to_hold_pre", 8'(func_hold_req), 8'h1);
    tick();
    sel_seen = sel_seen | ijtag_select;
    chk("to_hold0", 8'(func_hold_req), 8'h0);
    chk("to_no_sel", 8'(sel_seen), 8'h0);
    tick();
    chk("to_stays_idle", 8'(func_hold_req), 8'h0);
    capture_read(1'b0, v);
    chk("to_cap_flag", 8'(v), 8'h16);
    shift_word(5'b00000);
    pulse_update();
    capture_read(1'b0, v);
    chk("to_cap_clear", 8'(v), 8'h06);
`else
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (func_hold_req !== 1'b1 || ijtag_select !== 1'b0) ok = 1'b0;
    end
    chk("noto_hold_50", 8'(ok), 8'h1);
    capture_read(1'b0, v);
    chk("noto_cap", 8'(v), 8'h06);
    shift_word(5'b00000);
    pulse_update();
    tick();
    chk("noto_abort", 8'(func_hold_req), 8'h0);
`endif

    // abort during SETTLE
    func_idle = 1'b0;
    shift_word(5'b10001);
    pulse_update();
    tick();
    chk("ab_hold1", 8'(func_hold_req), 8'h1);
    shift_word(5'b00001);
    func_idle = 1'b1;
    ijtag_ue  = 1'b1;
    tick();
    ijtag_ue  = 1'b0;
    chk("ab_settle_hold", 8'(func_hold_req), 8'h1);
    chk("ab_settle_sel", 8'(ijtag_select), 8'h0);
    tick();
    chk("ab_hold0", 8'(func_hold_req), 8'h0);
    chk("ab_sel0", 8'(ijtag_select), 8'h0);
    tick();
    chk("ab_sel_after", 8'(ijtag_select), 8'h0);

    // reset mid-ACTIVE
    shift_word(5'b10111);
    pulse_update();
    tick(); tick(); tick(); tick();
    chk("ra_active", 8'(ijtag_select), 8'h1);
    chk("ra_data", 8'(ijtag_data_out), 8'h7);
    ijtag_reset = 1'b1;
    tick();
    ijtag_reset = 1'b0;
    chk("ra_sel0", 8'(ijtag_select), 8'h0);
    chk("ra_hold0", 8'(func_hold_req), 8'h0);
    chk("ra_data0", 8'(ijtag_data_out), 8'h0);
    functional_data_in = 3'b000;
    func_idle = 1'b0;
    capture_read(1'b0, v);
    chk("ra_cap0", 8'(v), 8'h00);
    chk("ra_idle", 8'(func_hold_req), 8'h0);

    // capture of 110 shifted out LSB first
    functional_data_in = 3'b110;
    ijtag_sel = 1'b1; ijtag_ce = 1'b1;
    tick();
    ijtag_ce = 1'b0;
    chk("so_bit0", 8'(ijtag_so), 8'h0);
    ijtag_se = 1'b1;
    tick();
    chk("so_bit1", 8'(ijtag_so), 8'h1);
    tick();
    chk("so_bit2", 8'(ijtag_so), 8'h1);
    ijtag_se = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
